// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU core.
//   DEF_ADDR_W / DEF_DATA_W : default address and word widths
//   OP_CLA .. OP_BAN        : opcode values carried in ir[7:4]
//   state_t                 : control FSM encoding (ST_FETCH, ST_EXEC, ST_HALT)
package cpu_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;
   localparam int OP_W       = 4;

   localparam logic [OP_W-1:0] OP_CLA = 4'h0;
   localparam logic [OP_W-1:0] OP_COM = 4'h1;
   localparam logic [OP_W-1:0] OP_SHR = 4'h2;
   localparam logic [OP_W-1:0] OP_CSL = 4'h3;
   localparam logic [OP_W-1:0] OP_STP = 4'h4;
   localparam logic [OP_W-1:0] OP_ADD = 4'h5;
   localparam logic [OP_W-1:0] OP_STA = 4'h6;
   localparam logic [OP_W-1:0] OP_LDA = 4'h7;
   localparam logic [OP_W-1:0] OP_JMP = 4'h8;
   localparam logic [OP_W-1:0] OP_BAN = 4'h9;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational accumulator update for one EXEC cycle.
//   op       : opcode field of the current instruction
//   acc      : current accumulator
//   operand  : RAM word at the operand address (used by ADD and LDA)
//   acc_next : accumulator value to register at the end of EXEC
// Opcodes that do not touch the accumulator pass it through unchanged.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] operand,
   output logic [DATA_W-1:0] acc_next
);

   always_comb begin
      acc_next = acc;
      case (op)
         OP_CLA:  acc_next = '0;
         OP_COM:  acc_next = ~acc;
         OP_SHR:  acc_next = {acc[DATA_W-1], acc[DATA_W-1:1]};
         OP_CSL:  acc_next = {acc[DATA_W-2:0], acc[DATA_W-1]};
         OP_ADD:  acc_next = acc + operand;
         OP_LDA:  acc_next = operand;
         default: acc_next = acc;
      endcase
   end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control/datapath core of the 8-bit accumulator CPU.
// Holds PC, IR and ACC and drives a 16x8 RAM with two combinational read
// ports; one instruction completes every FETCH+EXEC pair until STP.
//   clk, rst   : system clock, asynchronous active-high reset
//   step       : (SINGLE_STEP_EN only) FETCH waits for step=1
//   mdr_ins    : RAM word at addr_ins
//   mdr_data   : RAM word at addr_data
//   addr_ins   : instruction address (= pc)
//   addr_data  : operand address (= ir[3:0])
//   data_out   : RAM write data (= acc)
//   ram_we     : RAM write enable, sampled by the RAM on negedge clk
//   pc, acc    : program counter, accumulator
//   halted     : set once STP has executed
// Build option: define SINGLE_STEP_EN to add the step input.
//
// state    | meaning
// ST_FETCH | ir <= mdr_ins (waits for step when single-stepping)
// ST_EXEC  | execute ir: update acc/pc, STA drives ram_we this cycle
// ST_HALT  | STP executed; everything frozen until rst
module cpu_control_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
`ifdef SINGLE_STEP_EN
   input  logic              step,
`endif
   input  logic [DATA_W-1:0] mdr_ins,
   input  logic [DATA_W-1:0] mdr_data,
   output logic [ADDR_W-1:0] addr_ins,
   output logic [ADDR_W-1:0] addr_data,
   output logic [DATA_W-1:0] data_out,
   output logic              ram_we,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] acc,
   output logic              halted
);

   state_t            state;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] acc_next;
   logic [OP_W-1:0]   op;
   logic [ADDR_W-1:0] x;
   logic              fetch_go;

   assign op = ir[DATA_W-1 -: OP_W];
   assign x  = ir[ADDR_W-1:0];

`ifdef SINGLE_STEP_EN
   assign fetch_go = step;
`else
   assign fetch_go = 1'b1;
`endif

   assign addr_ins  = pc;
   assign addr_data = x;
   assign data_out  = acc;
   // Decoded from registers only, so it is settled well before the RAM's
   // negedge sample and drops as soon as rst clears state.
   assign ram_we = (state == ST_EXEC) && (op == OP_STA);

   cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .op       (op),
      .acc      (acc),
      .operand  (mdr_data),
      .acc_next (acc_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_FETCH;
         pc     <= RESET_PC;
         ir     <= '0;
         acc    <= '0;
         halted <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (fetch_go) begin
                  ir    <= mdr_ins;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               acc   <= acc_next;
               state <= ST_FETCH;
               case (op)
                  OP_STP: begin
                     halted <= 1'b1;
                     state  <= ST_HALT;
                  end
                  OP_JMP:  pc <= x;
                  // pc still holds the BAN address here, so the offset is relative to it
                  OP_BAN:  pc <= acc[DATA_W-1] ? pc + x : pc + ADDR_W'(1);
                  default: pc <= pc + ADDR_W'(1);
               endcase
            end
            ST_HALT: state <= ST_HALT;
            default: state <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: wraps the core with a 16x8 negedge-write RAM
// and compares it against an instruction-level model of the CPU.
module tb_cpu_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
`ifdef SINGLE_STEP_EN
   logic       step = 1'b1;
`endif
   logic [7:0] mdr_ins, mdr_data, data_out, acc;
   logic [3:0] addr_ins, addr_data, pc;
   logic       ram_we, halted;

   logic [7:0] mem [16];
   logic [7:0] img [16];
   logic       load_req = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   // instruction-level model
   int m_mem [16];
   int m_pc, m_acc;
   bit m_halt;

   always #5 clk = ~clk;

   cpu_control_unit dut (
      .clk       (clk),
      .rst       (rst),
`ifdef SINGLE_STEP_EN
      .step      (step),
`endif
      .mdr_ins   (mdr_ins),
      .mdr_data  (mdr_data),
      .addr_ins  (addr_ins),
      .addr_data (addr_data),
      .data_out  (data_out),
      .ram_we    (ram_we),
      .pc        (pc),
      .acc       (acc),
      .halted    (halted)
   );

   assign mdr_ins  = mem[addr_ins];
   assign mdr_data = mem[addr_data];

   always @(negedge clk) begin
      if (load_req) mem <= img;
      else if (ram_we) mem[addr_data] <= data_out;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int ins, op, x;
      if (m_halt) return;
      ins = m_mem[m_pc];
      op  = ins / 16;
      x   = ins % 16;
      case (op)
         0: m_acc = 0;
         1: m_acc = 255 - m_acc;
         2: m_acc = m_acc / 2 + ((m_acc >= 128) ? 128 : 0);
         3: m_acc = (m_acc * 2) % 256 + m_acc / 128;
         5: m_acc = (m_acc + m_mem[x]) % 256;
         6: m_mem[x] = m_acc;
         7: m_acc = m_mem[x];
         default: ;
      endcase
      if (op == 4)      m_halt = 1'b1;
      else if (op == 8) m_pc = x;
      else if (op == 9) m_pc = (m_acc >= 128) ? (m_pc + x) % 16 : (m_pc + 1) % 16;
      else              m_pc = (m_pc + 1) % 16;
   endtask

   // Loads img into RAM under reset, checks reset outputs, releases reset
   // just after a negedge so the next posedge is the first FETCH.
   task automatic load_and_reset();
      rst = 1'b1;
      load_req = 1'b1;
      @(negedge clk);
      #1 load_req = 1'b0;
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_acc", 32'(acc), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      for (int i = 0; i < 16; i++) m_mem[i] = int'(img[i]);
      m_pc = 0;
      m_acc = 0;
      m_halt = 1'b0;
      rst = 1'b0;
   endtask

   task automatic run_instrs(input int n);
      bit exp_we;
      for (int i = 0; i < n; i++) begin
         exp_we = !m_halt && (m_mem[m_pc] / 16 == 6);
         @(posedge clk);
         #1 chk("we_exec", 32'(ram_we), 32'(exp_we));
         @(posedge clk);
         model_step();
         #1;
         chk("pc", 32'(pc), 32'(m_pc));
         chk("acc", 32'(acc), 32'(m_acc));
         chk("halted", 32'(halted), 32'(m_halt));
         chk("we_fetch", 32'(ram_we), 32'd0);
      end
   endtask

   task automatic chk_mem();
      for (int i = 0; i < 16; i++) chk("mem", 32'(mem[i]), 32'(m_mem[i]));
   endtask

   task automatic clear_img(input logic [7:0] fill);
      for (int i = 0; i < 16; i++) img[i] = fill;
   endtask

   initial begin
      // asynchronous reset before any clock edge
      #1 rst = 1'b1;
      #1;
      chk("async_rst_pc", 32'(pc), 32'd0);
      chk("async_rst_acc", 32'(acc), 32'd0);
      chk("async_rst_we", 32'(ram_we), 32'd0);
      chk("async_rst_halted", 32'(halted), 32'd0);

      // sum program
      clear_img(8'h00);
      img[0] = 8'h79; img[1] = 8'h5A; img[2] = 8'h6A; img[3] = 8'h79; img[4] = 8'h5B;
      img[5] = 8'h93; img[6] = 8'h69; img[7] = 8'h81; img[8] = 8'h40;
      img[9] = 8'h09; img[10] = 8'h00; img[11] = 8'hFF;
      load_and_reset();
      run_instrs(70);
      chk_mem();
      chk("sum_halted", 32'(halted), 32'd1);
      chk("sum_m10", 32'(mem[10]), 32'h2D);
      chk("sum_m9", 32'(mem[9]), 32'h00);
      chk("sum_acc", 32'(acc), 32'hFF);
      chk("sum_pc", 32'(pc), 32'd8);

      // shift/rotate/complement sequence
      clear_img(8'h00);
      img[0] = 8'h78; img[1] = 8'h20; img[2] = 8'h30; img[3] = 8'h10; img[4] = 8'h00;
      img[5] = 8'h40; img[8] = 8'h81;
      load_and_reset();
      run_instrs(1); chk("seq_lda", 32'(acc), 32'h81);
      run_instrs(1); chk("seq_shr", 32'(acc), 32'hC0);
      run_instrs(1); chk("seq_csl", 32'(acc), 32'h81);
      run_instrs(1); chk("seq_com", 32'(acc), 32'h7E);
      run_instrs(1); chk("seq_cla", 32'(acc), 32'h00);

      // BAN at 14 with offset 3, taken (wraps) and not taken
      for (int t = 0; t < 2; t++) begin
         clear_img(8'hA0);
         img[0] = 8'h8D; img[13] = 8'h7C; img[14] = 8'h93;
         img[12] = (t == 0) ? 8'h80 : 8'h7F;
         load_and_reset();
         run_instrs(3);
         chk("ban_pc", 32'(pc), (t == 0) ? 32'd1 : 32'd15);
      end

      // opcode 1011 behaves as NOP
      clear_img(8'h00);
      img[0] = 8'h75; img[1] = 8'hA0; img[2] = 8'hB7; img[3] = 8'h40; img[5] = 8'h3C;
      img[7] = 8'h5A;
      load_and_reset();
      run_instrs(3);
      chk("nop_pc", 32'(pc), 32'd3);
      chk("nop_acc", 32'(acc), 32'h3C);
      chk("nop_m7", 32'(mem[7]), 32'h5A);
      chk_mem();

      // reset during the EXEC of STA
      clear_img(8'h00);
      img[0] = 8'h75; img[1] = 8'h66; img[5] = 8'h55; img[6] = 8'h11;
      load_and_reset();
      run_instrs(1);
      @(posedge clk);
      #1 chk("sta_we_before_rst", 32'(ram_we), 32'd1);
      #1 rst = 1'b1;
      #1 chk("sta_we_after_rst", 32'(ram_we), 32'd0);
      @(negedge clk);
      #1;
      chk("sta_rst_m6", 32'(mem[6]), 32'h11);
      chk("sta_rst_pc", 32'(pc), 32'd0);
      chk("sta_rst_acc", 32'(acc), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("sta_rel_pc", 32'(pc), 32'd0);
      chk("sta_rel_acc", 32'(acc), 32'd0);

      // randomized programs
      for (int p = 0; p < 12; p++) begin
         for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
         load_and_reset();
         run_instrs(24);
         chk_mem();
      end

`ifdef SINGLE_STEP_EN
      clear_img(8'h00);
      img[0] = 8'h75; img[1] = 8'h10; img[2] = 8'h55; img[3] = 8'h40; img[5] = 8'h21;
      step = 1'b0;
      load_and_reset();
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         chk("step_hold_pc", 32'(pc), 32'd0);
         chk("step_hold_acc", 32'(acc), 32'd0);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk) step = 1'b1;
         @(negedge clk) step = 1'b0;
         repeat (10) @(posedge clk);
         model_step();
         #1;
         chk("step_pc", 32'(pc), 32'(m_pc));
         chk("step_acc", 32'(acc), 32'(m_acc));
      end
      step = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
